imem_loader: RTL and testbench



---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_loader_packer.sv | 32 +++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction-memory loader.
//   IMEM_ADDR_W / IMEM_DATA_W : instruction memory geometry (256 x 16).
//   IDLE..CSUM                : loader FSM state encoding.
//   is_rx_state()             : states in which the loader accepts a byte.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CSUM receive state).
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 16;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LEN  = 3'd1;
  localparam logic [2:0] HI   = 3'd2;
  localparam logic [2:0] LO   = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] CSUM = 3'd6;

  function automatic logic is_rx_state(input logic [2:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return (s == LEN) || (s == HI) || (s == LO) || (s == CSUM);
`else
    return (s == LEN) || (s == HI) || (s == LO);
`endif
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// imem_byte_packer: pairs two stream bytes into one 16-bit instruction.
//   clk, rst_n  : clock, asynchronous active-low reset
//   hi_load     : latch in_byte as instruction[15:8]
//   lo_load     : in_byte is instruction[7:0]; word is presented next cycle
//   in_byte     : stream byte
//   word        : last completed instruction (holds between completions)
//   word_valid  : one-cycle pulse, the cycle after lo_load
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hi_load,
  input  logic        lo_load,
  input  logic [7:0]  in_byte,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0] hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= lo_load;
      if (hi_load) hi_q <= in_byte;
      if (lo_load) word <= {hi_q, in_byte};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a program byte stream into the 256x16 instruction memory.
// Stream format: LEN byte (word count, 0 means 256), then hi/lo byte pairs,
// then (with IMEM_LOADER_CHECKSUM_EN) one XOR checksum byte over LEN + data.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : session start pulse (honoured only in IDLE or DONE)
//   in_data/in_valid/in_ready : byte stream input
//   mem_we/mem_addr/mem_wdata : instruction memory write port
//   cpu_hold        : CPU stall while a session is in progress
//   busy            : session in progress
//   done            : sticky, last session completed
//   err             : sticky, last session checksum mismatch (0 without feature)
//   dbg_state       : current FSM state, for observation only
// Handshake: a byte moves on a rising edge where in_valid && in_ready; in_ready
// is registered from the next state, so it never depends on in_valid and a
// producer may hold in_valid high indefinitely.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [8:0]        cnt;       // 9 bits so a LEN of 0 can stand for 256 words
  logic [ADDR_W-1:0] idx;
  logic              acc;
  logic              start_ok;
  logic              next_busy;

  assign acc       = in_valid & in_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign next_busy = !((next_state == IDLE) || (next_state == DONE));
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = LEN;
      LEN:        if (acc) next_state = HI;
      HI:         if (acc) next_state = LO;
      LO:         if (acc) next_state = WR;
      WR: begin
        if (cnt == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = CSUM;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = HI;
        end
      end
      CSUM:       if (acc) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      mem_addr <= '0;
    end else begin
      state    <= next_state;
      in_ready <= is_rx_state(next_state);
      busy     <= next_busy;
      cpu_hold <= next_busy;
      done     <= (next_state == DONE);
      if (state == LEN && acc) begin
        cnt <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
        idx <= '0;
      end
      if (state == LO && acc) mem_addr <= idx;
      if (state == WR) begin
        cnt <= cnt - 9'd1;
        idx <= idx + 1'b1;
      end
    end
  end

  logic [15:0] packed_word;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .hi_load    (state == HI && acc),
    .lo_load    (state == LO && acc),
    .in_byte    (in_data),
    .word       (packed_word),
    .word_valid (mem_we)
  );

  assign mem_wdata = packed_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      if (start_ok) err <= 1'b0;
      if (state == LEN && acc)
        csum <= in_data;
      else if ((state == HI || state == LO) && acc)
        csum <= csum ^ in_data;
      if (state == CSUM && acc) err <= (in_data != csum);
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed load sessions for imem_loader,
// checked against a stream-level model of expected memory writes.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];   // {addr, data} of every write the model expects
  logic [7:0]  pkt[$];     // data bytes of the session being driven
  int          we_cnt = 0;
  int          done_rise = 0;
  logic        done_q = 1'b0;
  logic [7:0]  last_addr = 8'h00;
  logic [15:0] last_data = 16'h0000;
  logic [23:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        we_cnt++;
        last_addr = mem_addr;
        last_data = mem_wdata;
        chk("in_ready_during_write", {31'b0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_write actual addr=%0h data=%0h required none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {24'b0, mem_addr}, {24'b0, e[23:16]});
          chk("write_data", {16'b0, mem_wdata}, {16'b0, e[15:0]});
        end
      end
      if (done && !done_q) done_rise++;
      done_q = done;
    end else begin
      done_q = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    if (gap_max > 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual in_ready=0 required 1 byte=%0h", b);
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] model_csum(input int n_words);
    logic [7:0] cs;
    cs = n_words[7:0];
    foreach (pkt[i]) cs = cs ^ pkt[i];
    return cs;
  endfunction

  // Model: word i lands at address i mod 256 as {pkt[2i], pkt[2i+1]}.
  task automatic load_begin(input int n_words, input int gap_max, input bit mid_start);
    int words;
    words = (n_words == 0) ? 256 : n_words;
    for (int i = 0; i < words; i++) begin
      logic [7:0] a;
      a = i[7:0];
      exp_q.push_back({a, pkt[2*i], pkt[2*i+1]});
    end
    pulse_start();
    send_byte(n_words[7:0], gap_max);
    for (int i = 0; i < 2 * words; i++) begin
      send_byte(pkt[i], gap_max);
      if (mid_start && i == 1) begin
        in_valid = 1'b0;
        pulse_start();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_finish(input logic [7:0] csum_byte, input logic exp_err);
    int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum_byte, 0);
    in_valid = 1'b0;
`else
    if (csum_byte === 8'hxx) $display("unused checksum byte");
`endif
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_set", {31'b0, done}, 32'd1);
    chk("busy_clear", {31'b0, busy}, 32'd0);
    chk("hold_clear", {31'b0, cpu_hold}, 32'd0);
    chk("err_flag", {31'b0, err}, {31'b0, exp_err});
    chk("all_writes_seen", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic rand_pkt(input int words);
    pkt.delete();
    for (int i = 0; i < 2 * words; i++) pkt.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, d0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    chk("rst_busy_done_err", {29'b0, busy, done, err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed N=2, valid held high: C0 00 C1 04.
    pkt = '{8'hC0, 8'h00, 8'hC1, 8'h04};
    w0 = we_cnt;
    load_begin(2, 0, 1'b0);
    chk("t1_we_after_lo", {31'b0, mem_we}, 32'd1);
    chk("t1_addr1", {24'b0, mem_addr}, 32'h01);
    chk("t1_data1", {16'b0, mem_wdata}, 32'hC104);
    chk("t1_hold_in_wr", {31'b0, cpu_hold}, 32'd1);
    @(negedge clk);
    chk("t1_we_dropped", {31'b0, mem_we}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1_hold_in_csum", {31'b0, cpu_hold}, 32'd1);
`else
    chk("t1_hold_fell", {31'b0, cpu_hold}, 32'd0);
    chk("t1_done", {31'b0, done}, 32'd1);
`endif
    load_finish(model_csum(2), 1'b0);
    chk("t1_write_count", we_cnt - w0, 32'd2);

    // N=0 means 256 words; word i = {i, ~i}; index wraps after 0xFF.
    pkt.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      pkt.push_back(b);
      pkt.push_back(~b);
    end
    w0 = we_cnt;
    load_begin(0, 0, 1'b0);
    load_finish(model_csum(0), 1'b0);
    chk("n0_write_count", we_cnt - w0, 32'd256);
    chk("n0_last_addr", {24'b0, last_addr}, 32'hFF);
    chk("n0_last_data", {16'b0, last_data}, 32'hFF00);

    // N=3 with random valid gaps.
    rand_pkt(3);
    w0 = we_cnt;
    load_begin(3, 1, 1'b0);
    load_finish(model_csum(3), 1'b0);
    chk("gaps_write_count", we_cnt - w0, 32'd3);

    // start re-pulsed mid-session after word 0 must be ignored.
    rand_pkt(3);
    w0 = we_cnt;
    d0 = done_rise;
    load_begin(3, 0, 1'b1);
    load_finish(model_csum(3), 1'b0);
    chk("midstart_write_count", we_cnt - w0, 32'd3);
    chk("midstart_done_once", done_rise - d0, 32'd1);

    // Reset after the HI byte of word 1: word 0 stays written.
    pkt = '{8'hC0, 8'h00, 8'hAA, 8'hBB};
    exp_q.push_back({8'h00, 16'hC000});
    w0 = we_cnt;
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(pkt[0], 0);
    send_byte(pkt[1], 0);
    send_byte(pkt[2], 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {27'b0, in_ready, mem_we, cpu_hold, busy, done, err}, 32'd0);
    chk("arst_addr_data", {8'b0, mem_addr, mem_wdata}, 32'd0);
    chk("arst_word0_written", we_cnt - w0, 32'd1);
    chk("arst_queue_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pkt = '{8'h5A, 8'hA5};
    load_begin(1, 0, 1'b0);
    load_finish(model_csum(1), 1'b0);

    // Random sessions.
    for (int s = 0; s < 5; s++) begin
      int n;
      n = $urandom_range(1, 8);
      rand_pkt(n);
      load_begin(n, $urandom_range(0, 2), 1'b0);
      load_finish(model_csum(n), 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    pkt = '{8'h12, 8'h34};
    load_begin(1, 0, 1'b0);
    load_finish(8'h27, 1'b0);
    pkt = '{8'h12, 8'h34};
    load_begin(1, 0, 1'b0);
    load_finish(8'h00, 1'b1);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
